// File: rtl/frame_downloader_crop.sv
// Cropped frame reader: bursts a window of a stored frame from memory into a
// local buffer, then unpacks each word into pixels for the display queue.
module frame_downloader_crop #(
  parameter int MEMORY_BURST      = 32,
  parameter int ADDR_WIDTH        = 21,
  parameter int DATA_WIDTH        = 32,
  parameter int PIXEL_WIDTH       = 16,
  parameter int FRAME_WIDTH       = 480,
  parameter int FRAME_HEIGHT      = 272,
  parameter int ORIG_FRAME_WIDTH  = 640,
  parameter int ORIG_FRAME_HEIGHT = 480,
  parameter int X_OFFSET          = 80,
  parameter int Y_OFFSET          = 104
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   start,
  input  logic [ADDR_WIDTH-1:0]                  base_addr,
  output logic                                   busy,
  output logic                                   download_done,
  output logic                                   read_rq,
  output logic [ADDR_WIDTH-1:0]                  read_addr,
  output logic [$clog2(MEMORY_BURST+1)-1:0]      read_len,
  input  logic                                   read_ack,
  input  logic                                   read_valid,
  input  logic [DATA_WIDTH-1:0]                  read_data,
  input  logic                                   queue_full,
  output logic                                   wr_en,
  output logic [PIXEL_WIDTH:0]                   queue_data
);

  localparam int PPW     = DATA_WIDTH / PIXEL_WIDTH;
  localparam int WPL     = FRAME_WIDTH / PPW;
  localparam int OWPL    = ORIG_FRAME_WIDTH / PPW;
  localparam int X_WORDS = X_OFFSET / PPW;
  localparam int LEN_W   = $clog2(MEMORY_BURST + 1);
  localparam int IDX_W   = (MEMORY_BURST > 1) ? $clog2(MEMORY_BURST) : 1;
  localparam int PIX_W   = (PPW > 1) ? $clog2(PPW) : 1;
  localparam int ROW_W   = $clog2(FRAME_HEIGHT + 1);
  localparam int COL_W   = $clog2(WPL + 1);

  // Geometry sanity: a bad window would silently read outside the stored frame.
  if (DATA_WIDTH % PIXEL_WIDTH != 0) begin : g_bad_ratio
    $error("DATA_WIDTH must be a multiple of PIXEL_WIDTH");
  end
  if ((FRAME_WIDTH % PPW != 0) || (ORIG_FRAME_WIDTH % PPW != 0) || (X_OFFSET % PPW != 0)) begin : g_bad_align
    $error("frame widths and X_OFFSET must be multiples of pixels per word");
  end
  if ((X_OFFSET + FRAME_WIDTH > ORIG_FRAME_WIDTH) || (Y_OFFSET + FRAME_HEIGHT > ORIG_FRAME_HEIGHT)) begin : g_bad_window
    $error("crop window exceeds stored frame");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQUEST,
    S_FILL,
    S_DRAIN,
    S_NEXT,
    S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [ROW_W-1:0]      row_q, row_d;
  logic [COL_W-1:0]      col_q, col_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]      len_q, len_d;
  logic [LEN_W-1:0]      fill_idx_q, fill_idx_d;
  logic [LEN_W-1:0]      word_idx_q, word_idx_d;
  logic [PIX_W-1:0]      pix_idx_q, pix_idx_d;
  logic                  sof_q, sof_d;

  logic [DATA_WIDTH-1:0] burst_buf_q [MEMORY_BURST];
  logic                  buf_we;
  logic [DATA_WIDTH-1:0] cur_word;
  logic [PIXEL_WIDTH-1:0] cur_pixel;
  logic [COL_W-1:0]      col_next;
  logic [ROW_W-1:0]      row_next;

  function automatic logic [ADDR_WIDTH-1:0] line_addr(
    input logic [ADDR_WIDTH-1:0] base,
    input logic [ROW_W-1:0]      row,
    input logic [COL_W-1:0]      col
  );
    logic [ADDR_WIDTH-1:0] offset;
    offset = ADDR_WIDTH'((Y_OFFSET + int'(row)) * OWPL + X_WORDS + int'(col));
    return base + offset;
  endfunction

  // Full bursts until the tail of the line; the tail burst carries the remainder.
  function automatic logic [LEN_W-1:0] burst_len(input logic [COL_W-1:0] col);
    int remaining;
    remaining = WPL - int'(col);
    return (remaining > MEMORY_BURST) ? LEN_W'(MEMORY_BURST) : LEN_W'(remaining);
  endfunction

  assign read_addr = addr_q;
  assign read_len  = len_q;
  assign cur_word  = burst_buf_q[word_idx_q[IDX_W-1:0]];
  assign cur_pixel = PIXEL_WIDTH'(cur_word >> (int'(pix_idx_q) * PIXEL_WIDTH));

  always_comb begin
    state_d       = state_q;
    base_d        = base_q;
    row_d         = row_q;
    col_d         = col_q;
    addr_d        = addr_q;
    len_d         = len_q;
    fill_idx_d    = fill_idx_q;
    word_idx_d    = word_idx_q;
    pix_idx_d     = pix_idx_q;
    sof_d         = sof_q;
    col_next      = col_q;
    row_next      = row_q;
    buf_we        = 1'b0;
    read_rq       = 1'b0;
    wr_en         = 1'b0;
    download_done = 1'b0;
    queue_data    = '0;
    busy          = (state_q != S_IDLE);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          base_d  = base_addr;
          row_d   = '0;
          col_d   = '0;
          sof_d   = 1'b1;
          addr_d  = line_addr(base_addr, '0, '0);
          len_d   = burst_len('0);
          state_d = S_REQUEST;
        end
      end

      S_REQUEST: begin
        read_rq = 1'b1;
        if (read_ack) begin
          fill_idx_d = '0;
          state_d    = S_FILL;
        end
      end

      S_FILL: begin
        if (read_valid) begin
          buf_we     = 1'b1;
          fill_idx_d = fill_idx_q + LEN_W'(1);
          if (fill_idx_q == len_q - LEN_W'(1)) begin
            word_idx_d = '0;
            pix_idx_d  = '0;
            state_d    = S_DRAIN;
          end
        end
      end

      // The pointer only moves on accepted writes, so queue stalls lose nothing.
      S_DRAIN: begin
        queue_data = {sof_q, cur_pixel};
        wr_en      = !queue_full;
        if (wr_en) begin
          sof_d = 1'b0;
          if (pix_idx_q == PIX_W'(PPW - 1)) begin
            pix_idx_d = '0;
            if (word_idx_q == len_q - LEN_W'(1)) begin
              state_d = S_NEXT;
            end else begin
              word_idx_d = word_idx_q + LEN_W'(1);
            end
          end else begin
            pix_idx_d = pix_idx_q + PIX_W'(1);
          end
        end
      end

      S_NEXT: begin
        col_next = col_q + COL_W'(len_q);
        if (col_next == COL_W'(WPL)) begin
          col_next = '0;
          row_next = row_q + ROW_W'(1);
        end
        col_d = col_next;
        row_d = row_next;
        if (row_next == ROW_W'(FRAME_HEIGHT)) begin
          state_d = S_DONE;
        end else begin
          addr_d  = line_addr(base_q, row_next, col_next);
          len_d   = burst_len(col_next);
          state_d = S_REQUEST;
        end
      end

      S_DONE: begin
        download_done = 1'b1;
        state_d       = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      base_q     <= '0;
      row_q      <= '0;
      col_q      <= '0;
      addr_q     <= '0;
      len_q      <= '0;
      fill_idx_q <= '0;
      word_idx_q <= '0;
      pix_idx_q  <= '0;
      sof_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      row_q      <= row_d;
      col_q      <= col_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      fill_idx_q <= fill_idx_d;
      word_idx_q <= word_idx_d;
      pix_idx_q  <= pix_idx_d;
      sof_q      <= sof_d;
    end
  end

  // Buffer contents are only read after being filled, so no reset is needed.
  always_ff @(posedge clk) begin
    if (buf_we) begin
      burst_buf_q[fill_idx_q[IDX_W-1:0]] <= read_data;
    end
  end

endmodule
